display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, number of counter sources sharing one seven_segment instance (2..8).
REQ-002 The block SHALL have parameter NUM_SEGMENTS, default 4, digits per source and per display.
REQ-003 The block SHALL have parameter CLK_PER, default 10, clock period in ns.
REQ-004 The block SHALL have parameter DWELL_MS, default 2000, auto-rotate dwell time in ms; DWELL_CYC = DWELL_MS*1_000_000/CLK_PER.
REQ-005 The block SHALL have parameter BLANK_CYC, default 16, blanking length in clocks between sources (>=1).
REQ-006 The block SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-007 The block SHALL have ports: button_down  in  1  one-cycle advance request; hold  in  1  level, freezes auto-rotation.
REQ-008 The block SHALL have ports: src_valid  in  NUM_SRC  per-source enable; src_encoded  in  [NUM_SRC][NUM_SEGMENTS][3:0]  digit nibbles; src_dp  in  [NUM_SRC][NUM_SEGMENTS]  digit points.
REQ-009 The block SHALL have ports: encoded  out  [NUM_SEGMENTS][3:0]  to seven_segment; digit_point  out  NUM_SEGMENTS; blank  out  1  display off; sel  out  $clog2(NUM_SRC)  active source; switched  out  1  one-cycle pulse on sel change.

Function
REQ-010 FSM states SHOW and BLANK; dwell counter width $clog2(DWELL_CYC), blank counter width $clog2(BLANK_CYC+1).
REQ-011 In SHOW the dwell counter SHALL increment each clock while hold=0 and hold its value while hold=1.
REQ-012 An advance event SHALL fire in SHOW when (dwell counter = DWELL_CYC-1 and hold=0), or button_down=1, or src_valid[sel]=0.
REQ-013 Simultaneous advance causes SHALL produce exactly one advance.
REQ-014 Next source SHALL be the first index with src_valid=1 searching sel+1, sel+2, ... modulo NUM_SRC, wrapping past NUM_SRC-1 to 0.
REQ-015 If no other source is valid and src_valid[sel]=1, the advance SHALL only clear the dwell counter; sel, state and switched are unchanged.
REQ-016 On a real advance, sel SHALL update on the next clock, switched SHALL pulse high for that one clock and the dwell counter SHALL clear.
REQ-017 encoded and digit_point SHALL be registered copies of src_encoded[sel] and src_dp[sel], one clock latency from any input or sel change.
REQ-018 When all src_valid=0, blank SHALL be 1 and encoded, digit_point SHALL be 0; sel holds; scanning resumes the cycle after any source becomes valid.
REQ-019 button_down arriving in BLANK SHALL be ignored (not queued); hold has no effect in BLANK.

Reset
REQ-020 Reset SHALL be synchronous and active-high and SHALL override all other inputs in the same cycle.
REQ-021 During and on the clock after reset: sel=0, state=SHOW, both counters=0, encoded=0, digit_point=0, blank=1, switched=0.
REQ-022 Reset asserted mid-BLANK or mid-dwell SHALL abort immediately to the REQ-021 values without a switched pulse.
REQ-023 After reset, if src_valid[0]=0 the first cycle SHALL perform the REQ-012 forced advance.

Configuration
REQ-024 Macro DISP_SCHED_BLANK_EN SHALL control the blanking interval.
REQ-025 With DISP_SCHED_BLANK_EN defined, a real advance SHALL enter BLANK for exactly BLANK_CYC clocks with blank=1, encoded=0, digit_point=0, then return to SHOW showing the new sel.
REQ-026 Without DISP_SCHED_BLANK_EN, the BLANK state, blank counter and BLANK_CYC SHALL not exist in logic; the advance goes SHOW->SHOW, blank is 1 only under REQ-018/REQ-021.

Verification (CLK_PER=10, DWELL_MS=1 -> DWELL_CYC=100000, NUM_SRC=4, BLANK_CYC=16)
REQ-027 All src_valid=1, no input activity -> sel 0->1->2->3->0, switched pulses exactly every 100000 clocks (plus 16 with BLANK_EN).
REQ-028 src_valid=4'b1010 after reset -> forced advance, sel=1 within 2 clocks; then sel alternates 1,3; sources 0 and 2 never selected.
REQ-029 hold=1 at dwell count 50000 for 200000 clocks, then released -> no advance during hold; advance 50000 clocks after release.
REQ-030 button_down on the same clock as dwell expiry -> sel advances by exactly one, a single switched pulse.
REQ-031 BLANK_EN defined, button_down during clock 5 of BLANK -> BLANK lasts exactly 16 clocks; no second advance.
REQ-032 Reset asserted at BLANK clock 8 with sel=2 -> next clock sel=0, blank=1, switched=0; SHOW resumes with source 0 data after one more clock.

Source files
------------

// File: rtl/display_scheduler.sv
// Time-shares one seven_segment display among NUM_SRC counter sources.
// Define DISP_SCHED_BLANK_EN to insert a BLANK_CYC-clock blanking gap on each switch.
module display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int NUM_SEGMENTS = 4,
  parameter int CLK_PER      = 10,
  parameter int DWELL_MS     = 2000,
  parameter int BLANK_CYC    = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      button_down,
  input  logic                                      hold,
  input  logic [NUM_SRC-1:0]                        src_valid,
  input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0][3:0] src_encoded,
  input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0]      src_dp,
  output logic [NUM_SEGMENTS-1:0][3:0]              encoded,
  output logic [NUM_SEGMENTS-1:0]                   digit_point,
  output logic                                      blank,
  output logic [$clog2(NUM_SRC)-1:0]                sel,
  output logic                                      switched
);

  localparam longint DWELL_CYC =
    longint'(DWELL_MS) * 64'sd1000000 / longint'(CLK_PER);
  localparam int DW = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam int SW = $clog2(NUM_SRC);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] sel_d, nxt;
  logic          sw_d, found, hide, adv, in_show;

  // Round-robin search for the next valid source after sel
  always_comb begin
    logic [SW-1:0] idx;
    nxt   = sel;
    found = 1'b0;
    for (int i = 1; i < NUM_SRC; i++) begin
      idx = SW'((int'(sel) + i) % NUM_SRC);
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end

  assign adv = in_show &&
    ((dwell_q == DWELL_LAST && !hold) || button_down || !src_valid[sel]);

`ifdef DISP_SCHED_BLANK_EN
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  assign in_show = (state_q == SHOW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHOW;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    dwell_d = dwell_q;
    sel_d   = sel;
    sw_d    = 1'b0;
    case (state_q)
      SHOW: begin
        if (adv) begin
          dwell_d = '0;
          if (found) begin
            sel_d   = nxt;
            sw_d    = 1'b1;
            state_d = BLANK;
            bcnt_d  = '0;
          end
        end else if (!hold) begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          state_d = SHOW;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = SHOW;
    endcase
    hide = !(|src_valid) || (state_d == BLANK);
  end
`else
  assign in_show = 1'b1;

  always_comb begin
    dwell_d = dwell_q;
    sel_d   = sel;
    sw_d    = 1'b0;
    if (adv) begin
      dwell_d = '0;
      if (found) begin
        sel_d = nxt;
        sw_d  = 1'b1;
      end
    end else if (!hold) begin
      dwell_d = dwell_q + DW'(1);
    end
    hide = !(|src_valid);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sel         <= '0;
      dwell_q     <= '0;
      switched    <= 1'b0;
      blank       <= 1'b1;
      encoded     <= '0;
      digit_point <= '0;
    end else begin
      sel         <= sel_d;
      dwell_q     <= dwell_d;
      switched    <= sw_d;
      blank       <= hide;
      encoded     <= hide ? '0 : src_encoded[sel];
      digit_point <= hide ? '0 : src_dp[sel];
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized self-checking bench for display_scheduler against a
// dwell/blank-time reference model (DWELL_CYC scaled down to 40).
module tb_display_scheduler;

  localparam int NS = 4;
  localparam int DC = 40;
`ifdef DISP_SCHED_BLANK_EN
  localparam int BL = 16;
`else
  localparam int BL = 0;
`endif

  logic clk = 0;
  logic reset = 0, button_down = 0, hold = 0;
  logic [3:0] src_valid = 4'hf;
  logic [3:0][3:0][3:0] src_encoded = '0;
  logic [3:0][3:0] src_dp = '0;
  logic [3:0][3:0] encoded;
  logic [3:0] digit_point;
  logic blank, switched;
  logic [1:0] sel;

  int total = 0, bad = 0;

  display_scheduler #(
    .NUM_SRC(4), .NUM_SEGMENTS(4), .CLK_PER(25000),
    .DWELL_MS(1), .BLANK_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .button_down(button_down), .hold(hold),
    .src_valid(src_valid), .src_encoded(src_encoded), .src_dp(src_dp),
    .encoded(encoded), .digit_point(digit_point), .blank(blank),
    .sel(sel), .switched(switched)
  );

  always #5 clk = ~clk;

  // Reference model: time shown on current source, remaining blank time
  int m_sel = 0, m_dwell = 0, m_brem = 0;
  logic m_sw = 0, m_blank = 1;
  logic [15:0] m_enc = '0;
  logic [3:0] m_dp = '0;

  task automatic model();
    int old, nx;
    if (reset) begin
      m_sel = 0; m_dwell = 0; m_brem = 0;
      m_sw = 0; m_blank = 1; m_enc = '0; m_dp = '0;
    end else begin
      old = m_sel;
      m_sw = 0;
      if (m_brem > 0) m_brem--;
      else if ((m_dwell == DC - 1 && !hold) || button_down
               || !src_valid[m_sel]) begin
        m_dwell = 0;
        nx = -1;
        for (int k = 1; k < NS; k++)
          if (nx < 0 && src_valid[(m_sel + k) % NS]) nx = (m_sel + k) % NS;
        if (nx >= 0) begin
          m_sel = nx; m_sw = 1; m_brem = BL;
        end
      end else if (!hold) m_dwell++;
      m_blank = (src_valid == 0) || (m_brem > 0);
      m_enc = m_blank ? 16'h0 : src_encoded[old];
      m_dp = m_blank ? 4'h0 : src_dp[old];
    end
  endtask

  function automatic logic [23:0] expv();
    return {2'(m_sel), m_sw, m_blank, m_enc, m_dp};
  endfunction

  function automatic logic [23:0] dutv();
    return {sel, switched, blank, encoded, digit_point};
  endfunction

  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic rand_data();
    src_encoded = {$urandom(), $urandom()};
    src_dp = 16'($urandom());
  endtask

  task automatic do_reset(input logic [3:0] v);
    reset = 1; src_valid = v; button_down = 0; hold = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    rand_data();
    button_down = 1; hold = 1; src_valid = 4'(($urandom));
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (dutv() !== 24'h1_00000 || dutv() !== expv()) begin
        bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, dutv(), expv());
      end
    end
    reset = 0; button_down = 0; hold = 0;
  endtask

  task automatic test_rotate();
    int last, n;
    logic [1:0] prev;
    rand_data();
    do_reset(4'hf);
    last = 0; n = 0; prev = 0;
    for (int c = 1; c <= DC + 3 * (DC + BL) + 10; c++) begin
      tick();
      total++;
      if (dutv() !== expv()) begin
        bad++;
        $display("FAIL rotate c=%0d: got %h want %h", c, dutv(), expv());
      end
      if (switched) begin
        total++;
        if (sel !== prev + 2'd1 || c - last !== (n == 0 ? DC : DC + BL)) begin
          bad++;
          $display("FAIL rotate_step: sel %0d gap %0d, want sel %0d gap %0d",
                   sel, c - last, prev + 2'd1, n == 0 ? DC : DC + BL);
        end
        last = c; n++; prev = sel;
      end
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL rotate_count: got %0d want 4", n);
    end
  endtask

  task automatic test_sparse();
    int ok;
    rand_data();
    do_reset(4'b1010);
    ok = 0;
    for (int i = 0; i < 2 && !ok; i++) begin
      tick();
      if (sel == 2'd1) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sparse_first: sel %0d want 1", sel);
    end
    for (int c = 0; c < 3 * (DC + BL); c++) begin
      tick();
      total++;
      if (dutv() !== expv() || sel[0] !== 1'b1) begin
        bad++;
        $display("FAIL sparse c=%0d: got %h want %h", c, dutv(), expv());
      end
    end
  endtask

  task automatic test_hold();
    int n;
    rand_data();
    do_reset(4'hf);
    for (int i = 0; i < DC && m_dwell != DC / 2; i++) tick();
    hold = 1;
    for (int c = 0; c < 3 * DC; c++) begin
      tick();
      total++;
      if (dutv() !== expv() || switched !== 1'b0) begin
        bad++;
        $display("FAIL hold c=%0d: got %h want %h", c, dutv(), expv());
      end
    end
    hold = 0;
    n = 0;
    for (int i = 0; i < 2 * DC && !switched; i++) begin
      tick();
      n++;
    end
    total++;
    if (n !== DC / 2 || !switched) begin
      bad++;
      $display("FAIL hold_release: advance after %0d want %0d", n, DC / 2);
    end
  endtask

  task automatic test_button_expiry();
    logic [1:0] pre;
    rand_data();
    do_reset(4'hf);
    for (int i = 0; i < DC && m_dwell != DC - 1; i++) tick();
    pre = sel;
    button_down = 1;
    tick();
    button_down = 0;
    total++;
    if (sel !== pre + 2'd1 || switched !== 1'b1) begin
      bad++;
      $display("FAIL btn_expiry: sel %0d sw %b want sel %0d sw 1",
               sel, switched, pre + 2'd1);
    end
    for (int c = 0; c < BL + 5; c++) begin
      tick();
      total++;
      if (switched !== 1'b0 || sel !== pre + 2'd1 || dutv() !== expv()) begin
        bad++;
        $display("FAIL btn_single c=%0d: got %h want %h", c, dutv(), expv());
      end
    end
  endtask

`ifdef DISP_SCHED_BLANK_EN
  task automatic test_blank_button();
    int cnt;
    logic [1:0] s;
    rand_data();
    do_reset(4'hf);
    for (int i = 0; i < 2 * DC && !switched; i++) tick();
    s = sel; cnt = 0;
    for (int i = 0; i < 3 * BL; i++) begin
      button_down = (i == 4);
      if (blank) cnt++;
      total++;
      if (dutv() !== expv() || sel !== s || (i > 0 && switched)) begin
        bad++;
        $display("FAIL blank_btn i=%0d: got %h want %h", i, dutv(), expv());
      end
      tick();
    end
    button_down = 0;
    total++;
    if (cnt !== BL) begin
      bad++;
      $display("FAIL blank_len: got %0d want %0d", cnt, BL);
    end
  endtask
`else
  task automatic test_button_mid();
    rand_data();
    do_reset(4'hf);
    for (int i = 0; i < 10; i++) tick();
    button_down = 1;
    tick();
    button_down = 0;
    total++;
    if (sel !== 2'd1 || switched !== 1'b1 || blank !== 1'b0) begin
      bad++;
      $display("FAIL btn_mid: sel %0d sw %b blank %b want 1 1 0",
               sel, switched, blank);
    end
  endtask
`endif

  task automatic test_reset_mid();
    rand_data();
    do_reset(4'hf);
    for (int i = 0; i < 3 * (DC + BL) && !(switched && sel == 2); i++)
      tick();
    for (int i = 0; i < 7; i++) tick();
    reset = 1;
    tick();
    total++;
    if (sel !== 2'd0 || blank !== 1'b1 || switched !== 1'b0
        || encoded !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: sel %0d blank %b sw %b enc %h want 0 1 0 0",
               sel, blank, switched, encoded);
    end
    reset = 0;
    tick();
    total++;
    if (blank !== 1'b0 || encoded !== src_encoded[0]
        || digit_point !== src_dp[0] || dutv() !== expv()) begin
      bad++;
      $display("FAIL reset_resume: got %h want %h", dutv(), expv());
    end
  endtask

  task automatic test_all_invalid();
    logic [1:0] s;
    rand_data();
    do_reset(4'hf);
    for (int i = 0; i < 5; i++) tick();
    s = sel;
    src_valid = 4'h0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (dutv() !== expv() || blank !== 1'b1 || encoded !== 16'h0
          || sel !== s) begin
        bad++;
        $display("FAIL all_off c=%0d: got %h want %h", c, dutv(), expv());
      end
    end
    src_valid = 4'b0100;
    for (int c = 0; c < BL + 5; c++) begin
      tick();
      total++;
      if (dutv() !== expv()) begin
        bad++;
        $display("FAIL resume c=%0d: got %h want %h", c, dutv(), expv());
      end
    end
    total++;
    if (sel !== 2'd2 || blank !== 1'b0) begin
      bad++;
      $display("FAIL resume_end: sel %0d blank %b want 2 0", sel, blank);
    end
  endtask

  task automatic test_random();
    do_reset(4'hf);
    for (int c = 0; c < 4000; c++) begin
      rand_data();
      button_down = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      if ($urandom_range(0, 39) == 0) src_valid = 4'($urandom());
      reset = ($urandom_range(0, 299) == 0);
      tick();
      total++;
      if (dutv() !== expv()) begin
        bad++;
        $display("FAIL random c=%0d: got %h want %h", c, dutv(), expv());
      end
    end
    reset = 0; button_down = 0; hold = 0;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_sparse();
    test_hold();
    test_button_expiry();
`ifdef DISP_SCHED_BLANK_EN
    test_blank_button();
`else
    test_button_mid();
`endif
    test_reset_mid();
    test_all_invalid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
